cu_mem_arbiter: RTL
===================

Name: cu_mem_arbiter

Overview:
- Shares the single-port instruction/data SRAM between two requesters: instruction fetch (IF, read-only) and the MEM stage (loads/stores with byte enables).
- Single outstanding transaction; fixed-priority arbitration with MEM favoured and a starvation guard for IF.
- Sits between the CU fetch/memory stages and the SRAM macro. Sequences each access as accept, issue, wait and respond.

Parameters:
- ADDR_W, 32, request/SRAM address width.
- DATA_W, 32, data width; byte enables are DATA_W/8.
- SRAM_LAT, 1, cycles from the sram_en cycle until sram_rdata is valid (≥1).
- STARVE_MAX, 4, consecutive MEM grants while IF is pending before IF is forced to win.

Ports:
- soc_clk  in  1  system clock, rising edge.
- ARB_reset_n  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  IF read request.
- if_req_addr  in  ADDR_W  IF byte address.
- if_req_ready  out  1  IF request accepted this cycle.
- if_rsp_valid  out  1  one-cycle pulse; if_rsp_data valid.
- if_rsp_data  out  DATA_W  fetched word.
- mem_req_valid  in  1  MEM request.
- mem_req_we  in  1  1 = write, 0 = read.
- mem_req_addr  in  ADDR_W  MEM byte address.
- mem_req_be  in  4  write byte enables.
- mem_req_wdata  in  DATA_W  write data.
- mem_req_ready  out  1  MEM request accepted this cycle.
- mem_rsp_valid  out  1  one-cycle pulse; read data or write ack.
- mem_rsp_data  out  DATA_W  read word; 0 for writes.
- sram_en  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write.
- sram_addr  out  ADDR_W  word-aligned address.
- sram_be  out  4  SRAM byte enables.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data.
- arb_busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: while ARB_reset_n=0, all outputs are 0, the FSM is in IDLE and the starvation counter is 0. Reset mid-transaction drops the pending response; no rsp_valid is produced for it.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE: ready is combinational and asserted only to the granted requester when its valid is high. The accept is valid&&ready at the clock edge. On accept, the request is registered and the FSM goes to ISSUE.
- ISSUE: drives sram_en=1 for exactly one cycle, with sram_addr={addr[ADDR_W-1:2],2'b00}.
  - Reads: sram_we=0, sram_be=4'hF.
  - Writes: sram_we=1, sram_be=mem_req_be, sram_wdata=mem_req_wdata.
  - Next state is WAIT. The latency counter is loaded with SRAM_LAT-1.
- WAIT: decrements the counter. When the counter reaches 0, sram_rdata is captured and the FSM goes to RESP. With SRAM_LAT=1, WAIT lasts one cycle.
- RESP: the granted requester's rsp_valid is high for one cycle with the registered data; the FSM then returns to IDLE.
- Latency: accept cycle A, sram_en at A+1, rsp_valid at A+2+SRAM_LAT. One transaction every SRAM_LAT+3 cycles.
- No new accept is possible outside IDLE; ready stays 0 there.
- Arbitration in IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: MEM is granted, unless starve_cnt==STARVE_MAX, in which case IF is granted.
- Starvation counter:
  - Increments on each MEM grant while if_req_valid=1.
  - Clears on IF grant, or whenever if_req_valid=0 in IDLE.
  - Saturates at STARVE_MAX.
- Requester rules: valid, addr, we, be and wdata are held stable until ready. Responses have no backpressure; the requester must take rsp_valid.
- A write with be=4'b0000 is still accepted. sram_en stays 0 in ISSUE, and the response timing is unchanged: mem_rsp_valid is asserted with data 0.
- addr[1:0] is ignored (word access); sub-word placement is the requester's job via be.
- Unselected rsp_data outputs hold their previous value; only rsp_valid qualifies them.

Decomposition:
- Package cu_mem_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP).
  - arb_grant_t enum (GNT_IF, GNT_MEM).
  - BE_ALL=4'hF.
  - Default SRAM_LAT and STARVE_MAX constants.
- Sub-module cu_mem_arb_prio contains the grant decision and the saturating starvation counter. Its inputs are both valids, the IDLE flag and soc_clk/ARB_reset_n; its output is the grant.

Test Plan:
- IF-only read, addr 0x0000_0104, sram_rdata=0xDEAD_BEEF, SRAM_LAT=1 -> sram_en at A+1 with sram_addr 0x104; if_rsp_valid pulse at A+3 with data 0xDEAD_BEEF; mem_rsp_valid stays 0.
- MEM write, addr 0x0000_0203, be=4'b0110, wdata 0x1122_3344 -> sram_addr 0x200, sram_we=1, sram_be=4'b0110; mem_rsp_valid at A+3 with data 0.
- Both requesters valid continuously, STARVE_MAX=4 -> grant sequence MEM, MEM, MEM, MEM, IF, MEM, and so on; starvation counter back to 0 after the IF grant.
- MEM write with be=0 -> accepted; sram_en never asserted; mem_rsp_valid still at A+3.
- ARB_reset_n pulled low during WAIT -> all outputs 0 immediately; no rsp_valid after release; the next request completes normally from IDLE.
- SRAM_LAT=3 build, back-to-back IF reads -> rsp_valid at A+5; second accept no earlier than the cycle after RESP; arb_busy low only in IDLE.

Source files
------------

// File: rtl/cu_mem_pkg.sv
// Shared types and defaults for the CU instruction/data SRAM arbiter.
package cu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_MEM
  } arb_grant_t;

  localparam logic [3:0] BE_ALL         = 4'hF;
  localparam int         SRAM_LAT_DEF   = 1;
  localparam int         STARVE_MAX_DEF = 4;

endpackage

// File: rtl/cu_mem_arbiter_if.sv
// Request/response/SRAM bundle between the fetch and MEM stages, the arbiter and the SRAM macro.
// Requests complete when valid && ready at a rising edge; valid and payload must stay stable until then.
// Responses are single-cycle rsp_valid pulses with no backpressure.
interface cu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic              mem_req_valid;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [BE_W-1:0]   mem_req_be;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;

  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [BE_W-1:0]   sram_be;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic              arb_busy;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output sram_en, sram_we, sram_addr, sram_be, sram_wdata,
    input  sram_rdata,
    output arb_busy
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  sram_en, sram_we, sram_addr, sram_be, sram_wdata,
    output sram_rdata,
    input  arb_busy
  );

endinterface

// File: rtl/cu_mem_arb_prio.sv
// Grant decision for the SRAM arbiter: MEM wins ties unless IF has been passed over STARVE_MAX times.
module cu_mem_arb_prio
  import cu_mem_pkg::*;
#(
  parameter  int STARVE_MAX = STARVE_MAX_DEF,
  localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             soc_clk,
  input  logic             ARB_reset_n,
  input  logic             i_if_valid,
  input  logic             i_mem_valid,
  input  logic             i_idle,
  output arb_grant_t       o_gnt,
  output logic [CNT_W-1:0] o_starve_cnt
);

  localparam logic [CNT_W-1:0] STV_C = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_if;

  assign w_force_if   = (r_starve_cnt == STV_C);
  assign o_starve_cnt = r_starve_cnt;

  always_comb begin
    o_gnt = GNT_IF;
    if (i_mem_valid && !(i_if_valid && w_force_if)) o_gnt = GNT_MEM;
  end

  // In IDLE a grant to a valid requester is always an accept, so counting grants counts accepts.
  always_ff @(posedge soc_clk or negedge ARB_reset_n) begin
    if (!ARB_reset_n) begin
      r_starve_cnt <= '0;
    end else if (i_idle) begin
      if (!i_if_valid || o_gnt == GNT_IF) begin
        r_starve_cnt <= '0;
      end else if (i_mem_valid && r_starve_cnt != STV_C) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cu_mem_arbiter.sv
// Single-outstanding arbiter sharing one SRAM port between instruction fetch and the MEM stage.
module cu_mem_arbiter
  import cu_mem_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int SRAM_LAT   = SRAM_LAT_DEF,
  parameter  int STARVE_MAX = STARVE_MAX_DEF,
  localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic              soc_clk,
  input  logic              ARB_reset_n,
  cu_mem_arbiter_if.slave   bus,
  output arb_state_t        o_dbg_state,
  output logic [CNT_W-1:0]  o_dbg_starve
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

  arb_state_t        r_state, w_state_nxt;
  arb_grant_t        w_gnt, r_gnt;
  logic              r_we;
  logic [ADDR_W-3:0] r_word;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [LAT_W-1:0]  r_lat;
  logic [DATA_W-1:0] r_if_rdata, r_mem_rdata;
  logic              w_idle, w_if_acc, w_mem_acc, w_capture;

  // Ready must read 0 while reset is held, even though the state register already shows IDLE.
  assign w_idle    = (r_state == IDLE) && ARB_reset_n;
  assign w_if_acc  = w_idle && (w_gnt == GNT_IF)  && bus.if_req_valid;
  assign w_mem_acc = w_idle && (w_gnt == GNT_MEM) && bus.mem_req_valid;
  assign w_capture = (r_state == WAIT) && (r_lat == '0);

  cu_mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .soc_clk      (soc_clk),
    .ARB_reset_n  (ARB_reset_n),
    .i_if_valid   (bus.if_req_valid),
    .i_mem_valid  (bus.mem_req_valid),
    .i_idle       (w_idle),
    .o_gnt        (w_gnt),
    .o_starve_cnt (o_dbg_starve)
  );

  always_ff @(posedge soc_clk or negedge ARB_reset_n) begin
    if (!ARB_reset_n) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    bus.if_req_ready  = w_if_acc;
    bus.mem_req_ready = w_mem_acc;
    bus.if_rsp_valid  = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.sram_en       = 1'b0;
    bus.sram_we       = 1'b0;
    bus.sram_addr     = '0;
    bus.sram_be       = '0;
    bus.sram_wdata    = '0;
    case (r_state)
      IDLE: if (w_if_acc || w_mem_acc) w_state_nxt = ISSUE;
      ISSUE: begin
        // An all-zero byte-enable write skips the SRAM strobe but keeps the normal timing.
        if (r_be != '0) begin
          bus.sram_en    = 1'b1;
          bus.sram_we    = r_we;
          bus.sram_addr  = {r_word, 2'b00};
          bus.sram_be    = r_be;
          bus.sram_wdata = r_wdata;
        end
        w_state_nxt = WAIT;
      end
      WAIT: if (r_lat == '0) w_state_nxt = RESP;
      RESP: begin
        bus.if_rsp_valid  = (r_gnt == GNT_IF);
        bus.mem_rsp_valid = (r_gnt == GNT_MEM);
        w_state_nxt       = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or negedge ARB_reset_n) begin
    if (!ARB_reset_n) begin
      r_gnt       <= GNT_IF;
      r_we        <= 1'b0;
      r_word      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_lat       <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (w_if_acc) begin
        r_gnt   <= GNT_IF;
        r_we    <= 1'b0;
        r_word  <= bus.if_req_addr[ADDR_W-1:2];
        r_be    <= BE_W'(BE_ALL);
        r_wdata <= '0;
      end else if (w_mem_acc) begin
        r_gnt   <= GNT_MEM;
        r_we    <= bus.mem_req_we;
        r_word  <= bus.mem_req_addr[ADDR_W-1:2];
        r_be    <= bus.mem_req_we ? bus.mem_req_be : BE_W'(BE_ALL);
        r_wdata <= bus.mem_req_we ? bus.mem_req_wdata : '0;
      end
      if (r_state == ISSUE)                  r_lat <= LAT_W'(SRAM_LAT - 1);
      else if (r_state == WAIT && r_lat != '0) r_lat <= r_lat - LAT_W'(1);
      if (w_capture) begin
        if (r_gnt == GNT_IF) r_if_rdata  <= bus.sram_rdata;
        else                 r_mem_rdata <= r_we ? '0 : bus.sram_rdata;
      end
    end
  end

  assign bus.if_rsp_data  = r_if_rdata;
  assign bus.mem_rsp_data = r_mem_rdata;
  assign bus.arb_busy     = (r_state != IDLE);
  assign o_dbg_state      = r_state;

endmodule
